// File: rtl/ppu_vram_ctrl_if.sv
// VRAM responder bus for the PPU nametable port.
// master drives address/data/strobes, slave returns read data.
interface ppu_vram_ctrl_if #(
    parameter int VRAM_AW = 11
);
    logic [VRAM_AW-1:0] vram_addr;
    logic [7:0]         vram_data_out;
    logic               vram_en;
    logic               vram_rw;
    logic [7:0]         vram_data_in;

    modport master (
        output vram_addr,
        output vram_data_out,
        output vram_en,
        output vram_rw,
        input  vram_data_in
    );

    modport slave (
        input  vram_addr,
        input  vram_data_out,
        input  vram_en,
        input  vram_rw,
        output vram_data_in
    );
endinterface

// File: rtl/ppu_vram_ctrl.sv
// CPU-side PPUADDR/PPUDATA controller: two-write address latch, buffered
// reads, auto-increment and nametable mirroring onto a 2 KB VRAM.
module ppu_vram_ctrl #(
    parameter int ADDR_W  = 14,
    parameter int VRAM_AW = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_en,
    input  logic              cpu_rw,
    input  logic [2:0]        cpu_addr,
    input  logic [7:0]        cpu_data_in,
    output logic [7:0]        cpu_data_out,
    input  logic              inc32,
    input  logic              mirror_mode,
    input  logic              latch_reset,
    output logic              busy,
    output logic [ADDR_W-1:0] ppu_addr,
    ppu_vram_ctrl_if.master   vram
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_CAP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   v_q, v_d, v_wr;
    logic                w_q, w_d;
    logic                step32_q, step32_d;
    logic [7:0]          rbuf_q, rbuf_d;
    logic [7:0]          cpu_data_out_q, cpu_data_out_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [VRAM_AW-1:0]  vaddr_q, vaddr_d;
    logic [VRAM_AW-1:0]  map_addr;
    logic                addr_wr;
    logic                data_acc;
    logic                vram_tgt;
    logic                incr;
    logic                step_sel;

    always_comb begin
        addr_wr  = cpu_en && !cpu_rw && (cpu_addr == 3'd6);
        data_acc = cpu_en && (cpu_addr == 3'd7) && (state_q == IDLE);
        vram_tgt = (v_q[ADDR_W-1 -: 2] != 2'b00);
        map_addr = {(mirror_mode ? v_q[10] : v_q[11]), v_q[VRAM_AW-2:0]};
    end

    always_comb begin
        state_d        = state_q;
        step32_d       = step32_q;
        rbuf_d         = rbuf_q;
        cpu_data_out_d = cpu_data_out_q;
        wdata_d        = wdata_q;
        vaddr_d        = vaddr_q;
        incr           = 1'b0;
        step_sel       = step32_q;

        case (state_q)
            IDLE: begin
                step_sel = inc32;
                if (data_acc) begin
                    step32_d = inc32;
                    if (cpu_rw) begin
                        cpu_data_out_d = rbuf_q;
                    end
                    if (vram_tgt) begin
                        vaddr_d = map_addr;
                        if (cpu_rw) begin
                            state_d = RD_ADDR;
                        end else begin
                            state_d = WR;
                            wdata_d = cpu_data_in;
                        end
                    end else begin
                        incr = 1'b1;
                        if (cpu_rw) begin
                            rbuf_d = '0;
                        end
                    end
                end
            end
            WR: begin
                incr    = 1'b1;
                state_d = IDLE;
            end
            RD_ADDR: begin
                state_d = RD_CAP;
            end
            RD_CAP: begin
                rbuf_d  = vram.vram_data_in;
                incr    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A PPUADDR write lands first; any increment finishing this cycle adds onto it.
    always_comb begin
        v_wr = v_q;
        if (addr_wr) begin
            if (!w_q) begin
                v_wr[ADDR_W-1:8] = cpu_data_in[ADDR_W-9:0];
            end else begin
                v_wr[7:0] = cpu_data_in;
            end
        end
        v_d = v_wr + (incr ? ADDR_W'(step_sel ? 32 : 1) : '0);

        w_d = w_q;
        if (addr_wr) begin
            w_d = ~w_q;
        end
        if (latch_reset) begin
            w_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            v_q            <= '0;
            w_q            <= 1'b0;
            step32_q       <= 1'b0;
            rbuf_q         <= '0;
            cpu_data_out_q <= '0;
            wdata_q        <= '0;
            vaddr_q        <= '0;
        end else begin
            state_q        <= state_d;
            v_q            <= v_d;
            w_q            <= w_d;
            step32_q       <= step32_d;
            rbuf_q         <= rbuf_d;
            cpu_data_out_q <= cpu_data_out_d;
            wdata_q        <= wdata_d;
            vaddr_q        <= vaddr_d;
        end
    end

    assign busy               = (state_q != IDLE);
    assign cpu_data_out       = cpu_data_out_q;
    assign ppu_addr           = v_q;
    assign vram.vram_en       = (state_q != IDLE);
    assign vram.vram_rw       = (state_q == WR);
    assign vram.vram_addr     = vaddr_q;
    assign vram.vram_data_out = wdata_q;

endmodule

// File: tb/tb_ppu_vram_ctrl.sv
// Bench for ppu_vram_ctrl: vector table plus hand sequences, with a small
// VRAM responder and a reference model feeding read/write scoreboards.
module tb_ppu_vram_ctrl;

    localparam logic [1:0] OP_A = 2'd0;
    localparam logic [1:0] OP_W = 2'd1;
    localparam logic [1:0] OP_R = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_en = 1'b0;
    logic        cpu_rw = 1'b0;
    logic [2:0]  cpu_addr = 3'd0;
    logic [7:0]  cpu_data_in = 8'h00;
    logic [7:0]  cpu_data_out;
    logic        inc32 = 1'b0;
    logic        mirror_mode = 1'b0;
    logic        latch_reset = 1'b0;
    logic        busy;
    logic [13:0] ppu_addr;

    always #5 clk = ~clk;

    ppu_vram_ctrl_if vif();

    ppu_vram_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_en       (cpu_en),
        .cpu_rw       (cpu_rw),
        .cpu_addr     (cpu_addr),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .inc32        (inc32),
        .mirror_mode  (mirror_mode),
        .latch_reset  (latch_reset),
        .busy         (busy),
        .ppu_addr     (ppu_addr),
        .vram         (vif)
    );

    // Synchronous VRAM responder: read data valid one cycle after the address edge.
    logic [7:0] vram_mem [0:2047];
    logic [7:0] rd_q;
    int         wr_seen = 0;

    always @(posedge clk) begin
        if (vif.vram_en) begin
            if (vif.vram_rw) vram_mem[vif.vram_addr] <= vif.vram_data_out;
            rd_q <= vram_mem[vif.vram_addr];
        end
        if (vif.vram_en && vif.vram_rw) wr_seen <= wr_seen + 1;
    end
    assign vif.vram_data_in = rd_q;

    typedef struct packed {
        logic [1:0]  op;
        logic [7:0]  d;
        logic        inc;
        logic        mir;
        logic [13:0] ev;
    } vec_t;

    vec_t tbl [0:32];

    int          checks = 0;
    int          failures = 0;
    int          exp_wr = 0;
    logic [13:0] ref_v = '0;
    logic        ref_w = 1'b0;
    logic [7:0]  ref_buf = '0;
    logic [7:0]  ref_mem [0:2047];
    logic [18:0] wq [$];
    logic [7:0]  rq [$];

    function automatic vec_t tv(logic [1:0] op, logic [7:0] d, logic inc, logic mir, logic [13:0] ev);
        vec_t r;
        r.op = op; r.d = d; r.inc = inc; r.mir = mir; r.ev = ev;
        return r;
    endfunction

    function automatic logic [10:0] map_v(logic [13:0] v, logic m);
        return {(m ? v[10] : v[11]), v[9:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic addr_write(input logic [7:0] d, input logic lr);
        @(negedge clk);
        cpu_en = 1'b1; cpu_rw = 1'b0; cpu_addr = 3'd6; cpu_data_in = d; latch_reset = lr;
        if (!ref_w) ref_v[13:8] = d[5:0];
        else        ref_v[7:0]  = d;
        ref_w = lr ? 1'b0 : ~ref_w;
        @(negedge clk);
        cpu_en = 1'b0; latch_reset = 1'b0;
    endtask

    task automatic pulse_lr();
        @(negedge clk);
        latch_reset = 1'b1;
        ref_w = 1'b0;
        @(negedge clk);
        latch_reset = 1'b0;
    endtask

    task automatic data_access(input logic rd, input logic [7:0] d);
        logic [10:0] ma;
        logic        tgt;
        logic [18:0] ew;
        logic [7:0]  er;
        int          n;
        @(negedge clk);
        cpu_en = 1'b1; cpu_rw = rd; cpu_addr = 3'd7; cpu_data_in = d;
        tgt = (ref_v[13:12] != 2'b00);
        ma  = map_v(ref_v, mirror_mode);
        if (rd) begin
            rq.push_back(ref_buf);
            ref_buf = tgt ? ref_mem[ma] : 8'h00;
        end else if (tgt) begin
            wq.push_back({ma, d});
            ref_mem[ma] = d;
            exp_wr++;
        end
        ref_v = ref_v + (inc32 ? 14'd32 : 14'd1);
        @(negedge clk);
        cpu_en = 1'b0;
        if (rd) begin
            er = rq.pop_front();
            chk("rd_data", cpu_data_out, er);
        end else if (tgt) begin
            ew = wq.pop_front();
            chk("wr_cycle", {vif.vram_en, vif.vram_rw, vif.vram_addr, vif.vram_data_out}, {2'b11, ew});
        end
        n = 0;
        while (busy && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("busy_done", busy, 0);
    endtask

    initial begin
        logic [18:0] ew;
        logic [7:0]  er;
        for (int unsigned i = 0; i < 2048; i++) ref_mem[i] = 8'h00;

        tbl[0]  = tv(OP_A, 8'h21, 0, 1, 14'h2100);
        tbl[1]  = tv(OP_A, 8'h08, 0, 1, 14'h2108);
        tbl[2]  = tv(OP_W, 8'h5C, 0, 1, 14'h2109);
        tbl[3]  = tv(OP_W, 8'h77, 0, 1, 14'h210A);
        tbl[4]  = tv(OP_A, 8'h21, 0, 1, 14'h210A);
        tbl[5]  = tv(OP_A, 8'h08, 0, 1, 14'h2108);
        tbl[6]  = tv(OP_R, 8'h00, 0, 1, 14'h2109);
        tbl[7]  = tv(OP_R, 8'h00, 0, 1, 14'h210A);
        tbl[8]  = tv(OP_A, 8'h21, 0, 1, 14'h210A);
        tbl[9]  = tv(OP_A, 8'h08, 0, 1, 14'h2108);
        tbl[10] = tv(OP_W, 8'hAB, 0, 1, 14'h2109);
        tbl[11] = tv(OP_A, 8'h28, 0, 0, 14'h2809);
        tbl[12] = tv(OP_A, 8'h05, 0, 0, 14'h2805);
        tbl[13] = tv(OP_W, 8'h11, 0, 0, 14'h2806);
        tbl[14] = tv(OP_A, 8'h28, 0, 1, 14'h2806);
        tbl[15] = tv(OP_A, 8'h05, 0, 1, 14'h2805);
        tbl[16] = tv(OP_W, 8'h22, 0, 1, 14'h2806);
        tbl[17] = tv(OP_A, 8'h3F, 0, 0, 14'h3F06);
        tbl[18] = tv(OP_A, 8'hF0, 0, 0, 14'h3FF0);
        tbl[19] = tv(OP_W, 8'h33, 1, 0, 14'h0010);
        tbl[20] = tv(OP_A, 8'hFF, 0, 0, 14'h3F10);
        tbl[21] = tv(OP_A, 8'hFF, 0, 0, 14'h3FFF);
        tbl[22] = tv(OP_W, 8'h44, 0, 0, 14'h0000);
        tbl[23] = tv(OP_W, 8'h55, 0, 0, 14'h0001);
        tbl[24] = tv(OP_R, 8'h00, 0, 0, 14'h0002);
        tbl[25] = tv(OP_R, 8'h00, 0, 0, 14'h0003);
        tbl[26] = tv(OP_A, 8'h20, 0, 1, 14'h2003);
        tbl[27] = tv(OP_A, 8'h06, 0, 1, 14'h2006);
        tbl[28] = tv(OP_W, 8'h66, 0, 1, 14'h2007);
        tbl[29] = tv(OP_A, 8'h20, 0, 1, 14'h2007);
        tbl[30] = tv(OP_A, 8'h05, 0, 1, 14'h2005);
        tbl[31] = tv(OP_R, 8'h00, 0, 1, 14'h2006);
        tbl[32] = tv(OP_R, 8'h00, 1, 1, 14'h2026);

        #12;
        chk("rst_cpu_data_out", cpu_data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ppu_addr", ppu_addr, 0);
        chk("rst_vram_bus", {vif.vram_en, vif.vram_rw, vif.vram_addr, vif.vram_data_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 33; i++) begin
            inc32 = tbl[i].inc;
            mirror_mode = tbl[i].mir;
            case (tbl[i].op)
                OP_A:    addr_write(tbl[i].d, 1'b0);
                OP_W:    data_access(1'b0, tbl[i].d);
                default: data_access(1'b1, tbl[i].d);
            endcase
            chk($sformatf("vec%0d_v", i), ppu_addr, tbl[i].ev);
            chk($sformatf("vec%0d_wrcount", i), wr_seen, exp_wr);
        end

        // Write toggle: latch_reset between writes, and coincident with a write.
        inc32 = 1'b0; mirror_mode = 1'b1;
        addr_write(8'h21, 1'b0);
        pulse_lr();
        addr_write(8'h23, 1'b0);
        chk("lr_high_again", ppu_addr, 14'h2326);
        addr_write(8'h45, 1'b0);
        chk("lr_low", ppu_addr, 14'h2345);
        addr_write(8'h24, 1'b1);
        addr_write(8'h25, 1'b0);
        chk("lr_coincide", ppu_addr, 14'h2545);
        addr_write(8'h00, 1'b0);

        // PPUDATA write strobe held into WR: second strobe must be dropped.
        @(negedge clk);
        cpu_en = 1'b1; cpu_rw = 1'b0; cpu_addr = 3'd7; cpu_data_in = 8'h5A;
        wq.push_back({11'h500, 8'h5A});
        ref_mem[11'h500] = 8'h5A;
        exp_wr++;
        @(negedge clk);
        chk("drop_busy", busy, 1);
        ew = wq.pop_front();
        chk("drop_wr_cycle", {vif.vram_en, vif.vram_rw, vif.vram_addr, vif.vram_data_out}, {2'b11, ew});
        cpu_data_in = 8'h99;
        @(negedge clk);
        cpu_en = 1'b0;
        chk("drop_v", ppu_addr, 14'h2501);
        chk("drop_idle", busy, 0);
        @(negedge clk);
        chk("drop_wrcount", wr_seen, exp_wr);
        ref_v = 14'h2501;

        // Read with a dropped read strobe, then a PPUADDR write during RD_CAP.
        addr_write(8'h25, 1'b0);
        addr_write(8'h00, 1'b0);
        @(negedge clk);
        cpu_en = 1'b1; cpu_rw = 1'b1; cpu_addr = 3'd7;
        rq.push_back(ref_buf);
        ref_buf = ref_mem[11'h500];
        @(negedge clk);
        er = rq.pop_front();
        chk("busy_rd_data", cpu_data_out, er);
        @(negedge clk);
        chk("busy_rdcap", busy, 1);
        cpu_rw = 1'b0; cpu_addr = 3'd6; cpu_data_in = 8'h2A;
        @(negedge clk);
        cpu_en = 1'b0;
        chk("busy_addr_then_inc", ppu_addr, 14'h2A01);
        chk("busy_rd_idle", busy, 0);
        chk("drop_rd_hold", cpu_data_out, er);
        ref_v = 14'h2A01; ref_w = 1'b1;
        addr_write(8'h00, 1'b0);
        addr_write(8'h00, 1'b0);
        addr_write(8'h00, 1'b0);
        chk("v_zero", ppu_addr, 14'h0000);
        data_access(1'b1, 8'h00);

        // Reset while in RD_CAP.
        addr_write(8'h21, 1'b0);
        addr_write(8'h08, 1'b0);
        data_access(1'b1, 8'h00);
        @(negedge clk);
        cpu_en = 1'b1; cpu_rw = 1'b1; cpu_addr = 3'd7;
        @(negedge clk);
        cpu_en = 1'b0;
        chk("pre_rst_rd_data", cpu_data_out, ref_buf);
        @(negedge clk);
        chk("pre_rst_rdcap_en", vif.vram_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cpu_data_out", cpu_data_out, 0);
        chk("mid_rst_ppu_addr", ppu_addr, 0);
        chk("mid_rst_vram_bus", {vif.vram_en, vif.vram_rw, vif.vram_addr, vif.vram_data_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_v = '0; ref_w = 1'b0; ref_buf = 8'h00;
        addr_write(8'h21, 1'b0);
        addr_write(8'h09, 1'b0);
        data_access(1'b1, 8'h00);
        data_access(1'b1, 8'h00);
        chk("post_rst_v", ppu_addr, 14'h210B);
        chk("post_rst_wrcount", wr_seen, exp_wr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
